// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter and the cache controllers.
// Covers the arbiter state encoding and the line address/data widths.
package mem_arbiter_pkg;

    localparam int LINE_ADDR_W = 14;
    localparam int LINE_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        I_BUSY = 2'b01,
        D_BUSY = 2'b10
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating counter of consecutive dcache wins while icache is kept waiting.
// Raises at_limit once the count reaches LIMIT; clr takes precedence over inc.
module mem_arbiter_starve_cnt #(
    parameter int LIMIT = 3,
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [CNT_W-1:0] cnt;

    assign at_limit = (cnt == CNT_W'(LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory port between icache and dcache.
// dcache has fixed priority; icache is forced through after STARVE_LIMIT consecutive dcache wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_re,
    input  logic [LINE_ADDR_W-1:0] i_addr,
    output logic                   i_rdy,
    output logic [LINE_DATA_W-1:0] i_rd_data,
    input  logic                   d_re,
    input  logic                   d_we,
    input  logic [LINE_ADDR_W-1:0] d_addr,
    input  logic [LINE_DATA_W-1:0] d_wr_data,
    output logic                   d_rdy,
    output logic [LINE_DATA_W-1:0] d_rd_data,
    output logic                   m_re,
    output logic                   m_we,
    output logic [LINE_ADDR_W-1:0] m_addr,
    output logic [LINE_DATA_W-1:0] m_wr_data,
    input  logic [LINE_DATA_W-1:0] m_rd_data,
    input  logic                   m_rdy
);

    arb_state_e             state;
    logic [LINE_ADDR_W-1:0] addr_q;
    logic [LINE_DATA_W-1:0] wr_data_q;
    logic                   at_limit;
    logic                   grant_d;
    logic                   grant_i;

    // Grants are only evaluated in IDLE, which enforces the turnaround cycle between transactions.
    assign grant_d = (state == IDLE) && (d_re || d_we) && !(i_re && at_limit);
    assign grant_i = (state == IDLE) && i_re && !grant_d;

    mem_arbiter_starve_cnt #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (grant_d && i_re),
        .clr      (grant_i || (grant_d && !i_re)),
        .at_limit (at_limit)
    );

    // NOTE: the completion pulse is combinational from m_rdy so rdy lands in the same cycle;
    // it is gated by the registered state, so reset still silences it immediately.
    assign i_rdy     = (state == I_BUSY) && m_rdy;
    assign d_rdy     = (state == D_BUSY) && m_rdy;
    assign i_rd_data = i_rdy ? m_rd_data : '0;
    assign d_rd_data = d_rdy ? m_rd_data : '0;
    assign m_addr    = addr_q;
    assign m_wr_data = wr_data_q;

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            m_re      <= 1'b0;
            m_we      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= D_BUSY;
                        addr_q    <= d_addr;
                        wr_data_q <= d_wr_data;
                        m_we      <= d_we;
                        m_re      <= !d_we;
                    end else if (grant_i) begin
                        state  <= I_BUSY;
                        addr_q <= i_addr;
                        m_re   <= 1'b1;
                        m_we   <= 1'b0;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (m_rdy) begin
                        state <= IDLE;
                        m_re  <= 1'b0;
                        m_we  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    m_re  <= 1'b0;
                    m_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: the bench plays both cache controllers
// and the memory, and checks every memory-port cycle against hand-computed values.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_re;
    logic [13:0] i_addr;
    logic        i_rdy;
    logic [63:0] i_rd_data;
    logic        d_re;
    logic        d_we;
    logic [13:0] d_addr;
    logic [63:0] d_wr_data;
    logic        d_rdy;
    logic [63:0] d_rd_data;
    logic        m_re;
    logic        m_we;
    logic [13:0] m_addr;
    logic [63:0] m_wr_data;
    logic [63:0] m_rd_data;
    logic        m_rdy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .STARVE_LIMIT (3),
        .CNT_W        (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_re      (i_re),
        .i_addr    (i_addr),
        .i_rdy     (i_rdy),
        .i_rd_data (i_rd_data),
        .d_re      (d_re),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wr_data (d_wr_data),
        .d_rdy     (d_rdy),
        .d_rd_data (d_rd_data),
        .m_re      (m_re),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wr_data (m_wr_data),
        .m_rd_data (m_rd_data),
        .m_rdy     (m_rdy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_re"},      m_re,      0);
        check({tag, "_m_we"},      m_we,      0);
        check({tag, "_m_addr"},    m_addr,    0);
        check({tag, "_m_wr_data"}, m_wr_data, 0);
        check({tag, "_i_rdy"},     i_rdy,     0);
        check({tag, "_d_rdy"},     d_rdy,     0);
        check({tag, "_i_rd_data"}, i_rd_data, 0);
        check({tag, "_d_rd_data"}, d_rd_data, 0);
    endtask

    // Called with requests already driven, just after an edge with the arbiter in IDLE.
    // Expects the grant one edge later, then plays the memory for lat busy cycles.
    task automatic run_txn(input string tag, input bit is_d, input bit is_we,
                           input logic [13:0] exp_addr, input logic [63:0] exp_wdata,
                           input int lat, input logic [63:0] rdata,
                           input int chg_k, input logic [13:0] chg_addr);
        int n;
        n = 0;
        while (!(m_re || m_we) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_grant_lat"}, n, 1);
        for (int k = 1; k <= lat; k++) begin
            check({tag, "_m_re"},   m_re,   !is_we);
            check({tag, "_m_we"},   m_we,   is_we);
            check({tag, "_m_addr"}, m_addr, exp_addr);
            if (is_we) check({tag, "_m_wr_data"}, m_wr_data, exp_wdata);
            if (k == lat) begin
                m_rdy     = 1'b1;
                m_rd_data = rdata;
                #1;
                check({tag, "_i_rdy"}, i_rdy, !is_d);
                check({tag, "_d_rdy"}, d_rdy, is_d);
                if (!is_d) begin
                    check({tag, "_i_rd_data"}, i_rd_data, rdata);
                    check({tag, "_d_rd_data_idle"}, d_rd_data, 0);
                end else begin
                    check({tag, "_i_rd_data_idle"}, i_rd_data, 0);
                    if (!is_we) check({tag, "_d_rd_data"}, d_rd_data, rdata);
                end
            end else begin
                check({tag, "_i_rdy_early"}, i_rdy, 0);
                check({tag, "_d_rdy_early"}, d_rdy, 0);
            end
            if (k == chg_k) i_addr = chg_addr;
            @(posedge clk);
            #1;
            m_rdy     = 1'b0;
            m_rd_data = '0;
        end
        check({tag, "_turn_m_re"},  m_re,  0);
        check({tag, "_turn_m_we"},  m_we,  0);
        check({tag, "_turn_i_rdy"}, i_rdy, 0);
        check({tag, "_turn_d_rdy"}, d_rdy, 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        i_re      = 1'b0;
        i_addr    = '0;
        d_re      = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wr_data = '0;
        m_rd_data = '0;
        m_rdy     = 1'b0;

        #3;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("idle");

        // Icache line fill, 4-cycle memory.
        i_re   = 1'b1;
        i_addr = 14'h0123;
        run_txn("ird", 1'b0, 1'b0, 14'h0123, 64'h0, 4, 64'hDEADBEEF_00000001, 0, 14'h0);
        i_re = 1'b0;

        // Stray m_rdy while idle must not produce a completion.
        @(posedge clk);
        #1;
        m_rdy     = 1'b1;
        m_rd_data = 64'h1234;
        #1;
        check("stray_i_rdy", i_rdy, 0);
        check("stray_d_rdy", d_rdy, 0);
        @(posedge clk);
        #1;
        m_rdy     = 1'b0;
        m_rd_data = '0;
        check("stray_m_re", m_re, 0);

        // Both request together: dcache first, icache right after.
        i_re   = 1'b1;
        i_addr = 14'h0AAA;
        d_re   = 1'b1;
        d_addr = 14'h1555;
        run_txn("both_d", 1'b1, 1'b0, 14'h1555, 64'h0, 2, 64'h0000_1111_2222_3333, 0, 14'h0);
        d_re = 1'b0;
        run_txn("both_i", 1'b0, 1'b0, 14'h0AAA, 64'h0, 3, 64'h4444_5555_6666_7777, 0, 14'h0);
        i_re = 1'b0;

        // Write-back with d_re also high: the write wins.
        d_we      = 1'b1;
        d_re      = 1'b1;
        d_addr    = 14'h3FFF;
        d_wr_data = 64'hA5A5_A5A5_A5A5_A5A5;
        run_txn("dwr", 1'b1, 1'b1, 14'h3FFF, 64'hA5A5_A5A5_A5A5_A5A5, 3, 64'h0, 0, 14'h0);
        d_we = 1'b0;
        d_re = 1'b0;
        d_wr_data = '0;

        // Starvation guard: three dcache wins, then icache despite pending dcache.
        i_re   = 1'b1;
        i_addr = 14'h0077;
        d_re   = 1'b1;
        d_addr = 14'h0200;
        run_txn("starve_d1", 1'b1, 1'b0, 14'h0200, 64'h0, 1, 64'hD1, 0, 14'h0);
        run_txn("starve_d2", 1'b1, 1'b0, 14'h0200, 64'h0, 2, 64'hD2, 0, 14'h0);
        run_txn("starve_d3", 1'b1, 1'b0, 14'h0200, 64'h0, 1, 64'hD3, 0, 14'h0);
        run_txn("starve_i",  1'b0, 1'b0, 14'h0077, 64'h0, 2, 64'h1F, 0, 14'h0);
        // Counter was cleared by the icache win, so dcache wins again.
        run_txn("starve_d4", 1'b1, 1'b0, 14'h0200, 64'h0, 1, 64'hD4, 0, 14'h0);
        i_re = 1'b0;
        d_re = 1'b0;

        // Address change while busy is ignored.
        @(posedge clk);
        #1;
        i_re   = 1'b1;
        i_addr = 14'h0010;
        run_txn("addr_chg", 1'b0, 1'b0, 14'h0010, 64'h0, 4, 64'hCAFE_F00D, 2, 14'h0020);
        i_re = 1'b0;

        // Reset in D_BUSY abandons the transaction; held d_re is granted afresh.
        d_re   = 1'b1;
        d_addr = 14'h2222;
        @(posedge clk);
        #1;
        check("rstmid_busy_m_re", m_re, 1);
        check("rstmid_busy_m_addr", m_addr, 14'h2222);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("rstmid");
        m_rdy     = 1'b1;
        m_rd_data = 64'hBAD;
        #1;
        check("rstmid_no_d_rdy", d_rdy, 0);
        check("rstmid_no_d_data", d_rd_data, 0);
        m_rdy     = 1'b0;
        m_rd_data = '0;
        @(posedge clk);
        #1;
        check("rstmid_held_m_re", m_re, 0);
        rst = 1'b0;
        run_txn("rst_regrant", 1'b1, 1'b0, 14'h2222, 64'h0, 2, 64'h0BAD_BEEF, 0, 14'h0);
        d_re = 1'b0;

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
